exu_alu_lsuagu: RTL and testbench

//  Load/store address-generation and memory-access sequencer in the EXU. Accepts one load/store

---
 rtl/exu_alu_lsuagu_pkg.sv | 33 +++
 rtl/exu_lsu_dalgn.sv | 29 ++
 rtl/exu_alu_lsuagu.sv | 178 +++++++++++++++++
 tb/tb_exu_alu_lsuagu.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_alu_lsuagu_pkg.sv
// Shared definitions for the load/store address-generation sequencer.
// Contents: datapath width, byte-lane count, access-size codes, FSM state
// type, and the alignment rule shared by the FSM and the address register.
package exu_alu_lsuagu_pkg;

  localparam int XLEN  = 32;
  localparam int LANES = XLEN / 8;

  localparam logic [1:0] LSU_SIZE_B = 2'd0;
  localparam logic [1:0] LSU_SIZE_H = 2'd1;
  localparam logic [1:0] LSU_SIZE_W = 2'd2;

  typedef enum logic [2:0] {
    LSUAGU_IDLE,
    LSUAGU_AGEN,
    LSUAGU_CMD,
    LSUAGU_RSP,
    LSUAGU_WBCK
  } lsuagu_state_e;

  // Size code 3 is reserved and behaves like a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      LSU_SIZE_B: mis = 1'b0;
      LSU_SIZE_H: mis = off[0];
      LSU_SIZE_W: mis = (off != 2'd0);
      default:    mis = (off != 2'd0);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/exu_lsu_dalgn.sv
// Load-data aligner (purely combinational).
// Ports:
//   rdata  in   XLEN  word-aligned bus read data
//   off    in   2     byte offset of the access inside the word
//   size   in   2     access size code (B/H/W, 3 behaves as W)
//   usign  in   1     zero-extend instead of sign-extend for B/H
//   data   out  XLEN  load result shifted down to bit 0 and extended
module exu_lsu_dalgn
  import exu_alu_lsuagu_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [1:0]      size,
  input  logic            usign,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    case (size)
      LSU_SIZE_B: data = {{(XLEN-8){~usign & shifted[7]}}, shifted[7:0]};
      LSU_SIZE_H: data = {{(XLEN-16){~usign & shifted[15]}}, shifted[15:0]};
      default:    data = shifted;
    endcase
  end

endmodule

// File: rtl/exu_alu_lsuagu.sv
// Load/store address generation and memory-access sequencer.
// Takes one load/store from dispatch, borrows the shared ALU adder to form
// rs1+imm, checks alignment, issues one bus command, waits for its response,
// then presents a writeback/exception packet to commit. One op in flight.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   agu_i_*                        dispatch handshake and operands
//   agu_req_alu*, agu_req_alu_res  request to the shared adder, sum back
//   lsu_cmd_*                      bus command channel
//   lsu_rsp_*                      bus response channel
//   agu_o_*                        commit packet (data, rd, exceptions)
module exu_alu_lsuagu
  import exu_alu_lsuagu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            agu_i_valid,
  output logic            agu_i_ready,
  input  logic [XLEN-1:0] agu_i_rs1,
  input  logic [XLEN-1:0] agu_i_rs2,
  input  logic [XLEN-1:0] agu_i_imm,
  input  logic            agu_i_load,
  input  logic [1:0]      agu_i_size,
  input  logic            agu_i_usign,
  input  logic [4:0]      agu_i_rdidx,
  output logic            agu_req_alu,
  output logic [XLEN-1:0] agu_req_alu_op1,
  output logic [XLEN-1:0] agu_req_alu_op2,
  output logic            agu_req_alu_add,
  input  logic [XLEN-1:0] agu_req_alu_res,
  output logic            lsu_cmd_valid,
  input  logic            lsu_cmd_ready,
  output logic            lsu_cmd_read,
  output logic [XLEN-1:0] lsu_cmd_addr,
  output logic [XLEN-1:0] lsu_cmd_wdata,
  output logic [LANES-1:0] lsu_cmd_wmask,
  input  logic            lsu_rsp_valid,
  output logic            lsu_rsp_ready,
  input  logic [XLEN-1:0] lsu_rsp_rdata,
  input  logic            lsu_rsp_err,
  output logic            agu_o_valid,
  input  logic            agu_o_ready,
  output logic [XLEN-1:0] agu_o_wdat,
  output logic [4:0]      agu_o_rdidx,
  output logic            agu_o_rdwen,
  output logic            agu_o_misalgn,
  output logic            agu_o_buserr,
  output logic [XLEN-1:0] agu_o_badaddr
);

  lsuagu_state_e   state_reg, state_next;
  logic [XLEN-1:0] rs1_reg, rs2_reg, imm_reg, addr_reg, rdata_reg;
  logic            load_reg, usign_reg, misalgn_reg, buserr_reg;
  logic [1:0]      size_reg;
  logic [4:0]      rdidx_reg;
  logic            agen_misalgn;
  logic [LANES-1:0] mask_raw;
  logic [XLEN-1:0] ld_data;
  logic            load_ok;

  assign agen_misalgn = is_misaligned(size_reg, agu_req_alu_res[1:0]);

  // FSM next state and handshake outputs.
  always_comb begin
    state_next    = state_reg;
    agu_i_ready   = 1'b0;
    agu_req_alu   = 1'b0;
    lsu_cmd_valid = 1'b0;
    lsu_rsp_ready = 1'b0;
    agu_o_valid   = 1'b0;
    case (state_reg)
      LSUAGU_IDLE: begin
        agu_i_ready   = 1'b1;
        lsu_rsp_ready = 1'b1;  // swallow responses orphaned by a reset
        if (agu_i_valid) state_next = LSUAGU_AGEN;
      end
      LSUAGU_AGEN: begin
        agu_req_alu = 1'b1;
        state_next  = agen_misalgn ? LSUAGU_WBCK : LSUAGU_CMD;
      end
      LSUAGU_CMD: begin
        lsu_cmd_valid = 1'b1;
        if (lsu_cmd_ready) state_next = LSUAGU_RSP;
      end
      LSUAGU_RSP: begin
        lsu_rsp_ready = 1'b1;
        if (lsu_rsp_valid) state_next = LSUAGU_WBCK;
      end
      LSUAGU_WBCK: begin
        agu_o_valid = 1'b1;
        if (agu_o_ready) state_next = LSUAGU_IDLE;
      end
      default: state_next = LSUAGU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= LSUAGU_IDLE;
      rs1_reg     <= '0;
      rs2_reg     <= '0;
      imm_reg     <= '0;
      addr_reg    <= '0;
      rdata_reg   <= '0;
      load_reg    <= 1'b0;
      usign_reg   <= 1'b0;
      size_reg    <= 2'd0;
      rdidx_reg   <= 5'd0;
      misalgn_reg <= 1'b0;
      buserr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        LSUAGU_IDLE: if (agu_i_valid) begin
          rs1_reg     <= agu_i_rs1;
          rs2_reg     <= agu_i_rs2;
          imm_reg     <= agu_i_imm;
          load_reg    <= agu_i_load;
          size_reg    <= agu_i_size;
          usign_reg   <= agu_i_usign;
          rdidx_reg   <= agu_i_rdidx;
          misalgn_reg <= 1'b0;
          buserr_reg  <= 1'b0;
        end
        LSUAGU_AGEN: begin
          addr_reg    <= agu_req_alu_res;
          misalgn_reg <= agen_misalgn;
        end
        LSUAGU_RSP: if (lsu_rsp_valid) begin
          rdata_reg  <= lsu_rsp_rdata;
          buserr_reg <= lsu_rsp_err;
        end
        default: ;
      endcase
    end
  end

  assign agu_req_alu_op1 = rs1_reg;
  assign agu_req_alu_op2 = imm_reg;
  assign agu_req_alu_add = agu_req_alu;

  // Store data is replicated into every lane so the strobes alone select bytes.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lsu_cmd_wdata[8*gi +: 8] =
        (size_reg == LSU_SIZE_B) ? rs2_reg[7:0] :
        (size_reg == LSU_SIZE_H) ? rs2_reg[8*(gi%2) +: 8] :
                                   rs2_reg[8*gi +: 8];
  end

  always_comb begin
    case (size_reg)
      LSU_SIZE_B: mask_raw = 4'b0001 << addr_reg[1:0];
      LSU_SIZE_H: mask_raw = 4'b0011 << addr_reg[1:0];
      default:    mask_raw = 4'b1111;
    endcase
  end

  assign lsu_cmd_read  = load_reg;
  assign lsu_cmd_addr  = addr_reg;
  assign lsu_cmd_wmask = (lsu_cmd_valid && !load_reg) ? mask_raw : '0;

  exu_lsu_dalgn u_dalgn (
    .rdata (rdata_reg),
    .off   (addr_reg[1:0]),
    .size  (size_reg),
    .usign (usign_reg),
    .data  (ld_data)
  );

  assign load_ok       = load_reg & ~misalgn_reg & ~buserr_reg;
  assign agu_o_wdat    = load_ok ? ld_data : '0;
  assign agu_o_rdidx   = rdidx_reg;
  assign agu_o_rdwen   = load_ok & (rdidx_reg != 5'd0);
  assign agu_o_misalgn = misalgn_reg;
  assign agu_o_buserr  = buserr_reg;
  assign agu_o_badaddr = (misalgn_reg | buserr_reg) ? addr_reg : '0;

endmodule

// File: tb/tb_exu_alu_lsuagu.sv
// Self-checking bench for exu_alu_lsuagu: directed scenarios followed by
// randomized loads/stores, compared cycle by cycle against a reference
// model built from plain address/lane arithmetic.
module tb_exu_alu_lsuagu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        agu_i_valid = 1'b0;
  logic        agu_i_ready;
  logic [31:0] agu_i_rs1 = '0, agu_i_rs2 = '0, agu_i_imm = '0;
  logic        agu_i_load = 1'b0;
  logic [1:0]  agu_i_size = '0;
  logic        agu_i_usign = 1'b0;
  logic [4:0]  agu_i_rdidx = '0;
  logic        agu_req_alu, agu_req_alu_add;
  logic [31:0] agu_req_alu_op1, agu_req_alu_op2, agu_req_alu_res;
  logic        lsu_cmd_valid, lsu_cmd_read;
  logic        lsu_cmd_ready = 1'b0;
  logic [31:0] lsu_cmd_addr, lsu_cmd_wdata;
  logic [3:0]  lsu_cmd_wmask;
  logic        lsu_rsp_valid = 1'b0;
  logic        lsu_rsp_ready;
  logic [31:0] lsu_rsp_rdata = '0;
  logic        lsu_rsp_err = 1'b0;
  logic        agu_o_valid;
  logic        agu_o_ready = 1'b0;
  logic [31:0] agu_o_wdat, agu_o_badaddr;
  logic [4:0]  agu_o_rdidx;
  logic        agu_o_rdwen, agu_o_misalgn, agu_o_buserr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Shared ALU datapath: combinational adder.
  assign agu_req_alu_res = agu_req_alu_op1 + agu_req_alu_op2;

  exu_alu_lsuagu dut (
    .clk(clk), .rst_n(rst_n),
    .agu_i_valid(agu_i_valid), .agu_i_ready(agu_i_ready),
    .agu_i_rs1(agu_i_rs1), .agu_i_rs2(agu_i_rs2), .agu_i_imm(agu_i_imm),
    .agu_i_load(agu_i_load), .agu_i_size(agu_i_size), .agu_i_usign(agu_i_usign),
    .agu_i_rdidx(agu_i_rdidx),
    .agu_req_alu(agu_req_alu), .agu_req_alu_op1(agu_req_alu_op1),
    .agu_req_alu_op2(agu_req_alu_op2), .agu_req_alu_add(agu_req_alu_add),
    .agu_req_alu_res(agu_req_alu_res),
    .lsu_cmd_valid(lsu_cmd_valid), .lsu_cmd_ready(lsu_cmd_ready),
    .lsu_cmd_read(lsu_cmd_read), .lsu_cmd_addr(lsu_cmd_addr),
    .lsu_cmd_wdata(lsu_cmd_wdata), .lsu_cmd_wmask(lsu_cmd_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
    .lsu_rsp_rdata(lsu_rsp_rdata), .lsu_rsp_err(lsu_rsp_err),
    .agu_o_valid(agu_o_valid), .agu_o_ready(agu_o_ready),
    .agu_o_wdat(agu_o_wdat), .agu_o_rdidx(agu_o_rdidx), .agu_o_rdwen(agu_o_rdwen),
    .agu_o_misalgn(agu_o_misalgn), .agu_o_buserr(agu_o_buserr),
    .agu_o_badaddr(agu_o_badaddr)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic        load;
    logic [1:0]  size;
    logic        usign;
    logic [31:0] rs1, imm, rs2, rdata;
    logic [4:0]  rdidx;
    logic        err;
    int          cmd_dly, rsp_dly, o_dly;
  } txn_t;

  function automatic txn_t mk(input logic load, input logic [1:0] size, input logic usign,
                              input logic [31:0] rs1, input logic [31:0] imm,
                              input logic [31:0] rs2, input logic [4:0] rdidx,
                              input logic [31:0] rdata, input logic err,
                              input int cmd_dly, input int rsp_dly, input int o_dly);
    txn_t t;
    t.load = load; t.size = size; t.usign = usign; t.rs1 = rs1; t.imm = imm;
    t.rs2 = rs2; t.rdidx = rdidx; t.rdata = rdata; t.err = err;
    t.cmd_dly = cmd_dly; t.rsp_dly = rsp_dly; t.o_dly = o_dly;
    return t;
  endfunction

  // Reference model: sizes in bytes, lanes via arithmetic.
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic ref_mis(input logic [1:0] size, input logic [31:0] addr);
    return (addr % nbytes(size)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input txn_t t, input logic [31:0] addr);
    logic [31:0] v;
    int n;
    n = nbytes(t.size);
    v = t.rdata >> (8 * (addr % 4));
    if (n == 1) begin
      v = v % 256;
      if (!t.usign && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (n == 2) begin
      v = v % 65536;
      if (!t.usign && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_wdata(input txn_t t);
    int n;
    n = nbytes(t.size);
    if (n == 1) return (t.rs2 % 256) * 32'h0101_0101;
    if (n == 2) return (t.rs2 % 65536) * 32'h0001_0001;
    return t.rs2;
  endfunction

  function automatic logic [31:0] ref_wmask(input txn_t t, input logic [31:0] addr);
    int n;
    n = nbytes(t.size);
    return ((32'd1 << n) - 1) << (addr % 4);
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, ":i_ready"},   32'(agu_i_ready), 32'd1);
    chk({tag, ":req_alu"},   32'(agu_req_alu), 32'd0);
    chk({tag, ":alu_op1"},   agu_req_alu_op1, 32'd0);
    chk({tag, ":alu_op2"},   agu_req_alu_op2, 32'd0);
    chk({tag, ":cmd_valid"}, 32'(lsu_cmd_valid), 32'd0);
    chk({tag, ":cmd_addr"},  lsu_cmd_addr, 32'd0);
    chk({tag, ":cmd_wdata"}, lsu_cmd_wdata, 32'd0);
    chk({tag, ":cmd_wmask"}, 32'(lsu_cmd_wmask), 32'd0);
    chk({tag, ":rsp_ready"}, 32'(lsu_rsp_ready), 32'd1);
    chk({tag, ":o_valid"},   32'(agu_o_valid), 32'd0);
    chk({tag, ":o_wdat"},    agu_o_wdat, 32'd0);
    chk({tag, ":o_rdidx"},   32'(agu_o_rdidx), 32'd0);
    chk({tag, ":o_rdwen"},   32'(agu_o_rdwen), 32'd0);
    chk({tag, ":o_misalgn"}, 32'(agu_o_misalgn), 32'd0);
    chk({tag, ":o_buserr"},  32'(agu_o_buserr), 32'd0);
    chk({tag, ":o_badaddr"}, agu_o_badaddr, 32'd0);
  endtask

  // Runs one transaction, acting as dispatch, bus and commit, and checks
  // every output on every cycle from acceptance until the commit handshake.
  task automatic run_txn(input string name, input txn_t t);
    logic [31:0] addr, exp_wdat, exp_bad;
    logic        mis, ok, exp_cv, exp_ov;
    int          k, lat, cmd_wait, rsp_wait, o_wait;
    bit          cmd_done, rsp_done, done, o_seen;
    addr     = t.rs1 + t.imm;
    mis      = ref_mis(t.size, addr);
    ok       = t.load && !mis && !t.err;
    exp_wdat = ok ? ref_load(t, addr) : 32'd0;
    exp_bad  = (mis || t.err) ? addr : 32'd0;
    lat      = mis ? 2 : 4 + t.cmd_dly + t.rsp_dly;
    cmd_wait = 0; rsp_wait = 0; o_wait = 0;
    cmd_done = 0; rsp_done = 0; done = 0; o_seen = 0;

    @(negedge clk);
    chk({name, ":i_ready_idle"}, 32'(agu_i_ready), 32'd1);
    agu_i_valid = 1'b1; agu_i_rs1 = t.rs1; agu_i_imm = t.imm; agu_i_rs2 = t.rs2;
    agu_i_load = t.load; agu_i_size = t.size; agu_i_usign = t.usign; agu_i_rdidx = t.rdidx;
    @(negedge clk);
    // Scramble dispatch inputs: the DUT must work from its latched copy.
    agu_i_valid = 1'b0; agu_i_rs1 = $urandom; agu_i_imm = $urandom; agu_i_rs2 = $urandom;
    agu_i_load = 1'($urandom); agu_i_size = 2'($urandom); agu_i_usign = 1'($urandom);
    agu_i_rdidx = 5'($urandom);

    k = 1;
    while (!done && k < 100) begin
      if (lsu_cmd_ready) begin lsu_cmd_ready = 1'b0; cmd_done = 1; end
      if (lsu_rsp_valid) begin lsu_rsp_valid = 1'b0; rsp_done = 1; end
      if (agu_o_ready)   begin agu_o_ready = 1'b0;   done = 1;     end
      if (!done) begin
        chk({name, ":i_ready_busy"}, 32'(agu_i_ready), 32'd0);
        chk({name, ":req_alu"}, 32'(agu_req_alu), 32'(k == 1));
        chk({name, ":req_alu_add"}, 32'(agu_req_alu_add), 32'(k == 1));
        if (k == 1) begin
          chk({name, ":alu_op1"}, agu_req_alu_op1, t.rs1);
          chk({name, ":alu_op2"}, agu_req_alu_op2, t.imm);
        end
        exp_cv = !mis && k >= 2 && !cmd_done;
        chk({name, ":cmd_valid"}, 32'(lsu_cmd_valid), 32'(exp_cv));
        if (exp_cv && lsu_cmd_valid) begin
          chk({name, ":cmd_read"}, 32'(lsu_cmd_read), 32'(t.load));
          chk({name, ":cmd_addr"}, lsu_cmd_addr, addr);
          chk({name, ":cmd_wmask"}, 32'(lsu_cmd_wmask), t.load ? 32'd0 : ref_wmask(t, addr));
          if (!t.load) chk({name, ":cmd_wdata"}, lsu_cmd_wdata, ref_wdata(t));
          if (cmd_wait == t.cmd_dly) lsu_cmd_ready = 1'b1;
          else cmd_wait++;
        end
        if (cmd_done && !rsp_done) begin
          if (rsp_wait == t.rsp_dly) begin
            chk({name, ":rsp_ready"}, 32'(lsu_rsp_ready), 32'd1);
            lsu_rsp_valid = 1'b1; lsu_rsp_rdata = t.rdata; lsu_rsp_err = t.err;
          end else rsp_wait++;
        end
        exp_ov = mis ? (k >= 2) : rsp_done;
        chk({name, ":o_valid"}, 32'(agu_o_valid), 32'(exp_ov));
        if (exp_ov && agu_o_valid) begin
          if (!o_seen) chk({name, ":o_latency"}, 32'(k), 32'(lat));
          o_seen = 1;
          chk({name, ":o_wdat"},    agu_o_wdat, exp_wdat);
          chk({name, ":o_rdidx"},   32'(agu_o_rdidx), 32'(t.rdidx));
          chk({name, ":o_rdwen"},   32'(agu_o_rdwen), 32'(ok && t.rdidx != 5'd0));
          chk({name, ":o_misalgn"}, 32'(agu_o_misalgn), 32'(mis));
          chk({name, ":o_buserr"},  32'(agu_o_buserr), 32'(!mis && t.err));
          chk({name, ":o_badaddr"}, agu_o_badaddr, exp_bad);
          if (o_wait == t.o_dly) agu_o_ready = 1'b1;
          else o_wait++;
        end
        k++;
        @(negedge clk);
      end
    end
    if (!done) begin
      chk({name, ":timeout"}, 32'd0, 32'd1);
      lsu_cmd_ready = 1'b0; lsu_rsp_valid = 1'b0; agu_o_ready = 1'b0;
    end
    lsu_rsp_err = 1'b0;
    $display("txn %-10s load=%0d size=%0d addr=0x%08h mis=%0d err=%0d wdat=0x%08h", name,
             t.load, t.size, addr, mis, t.err, exp_wdat);
  endtask

  // Reset while waiting for a response, then deliver the orphaned response.
  task automatic reset_abort();
    @(negedge clk);
    chk("abort:i_ready", 32'(agu_i_ready), 32'd1);
    agu_i_valid = 1'b1; agu_i_load = 1'b1; agu_i_size = 2'd2; agu_i_usign = 1'b0;
    agu_i_rs1 = 32'h2000_0000; agu_i_imm = 32'd8; agu_i_rdidx = 5'd3;
    @(negedge clk);
    agu_i_valid = 1'b0;
    @(negedge clk);
    chk("abort:cmd_valid", 32'(lsu_cmd_valid), 32'd1);
    lsu_cmd_ready = 1'b1;
    @(negedge clk);
    lsu_cmd_ready = 1'b0;
    chk("abort:rsp_wait", 32'(lsu_rsp_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_state("abort_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    lsu_rsp_valid = 1'b1; lsu_rsp_rdata = 32'hCAFE_F00D; lsu_rsp_err = 1'b0;
    chk("abort:drain_ready", 32'(lsu_rsp_ready), 32'd1);
    @(negedge clk);
    lsu_rsp_valid = 1'b0;
    chk("abort:drain_o_valid", 32'(agu_o_valid), 32'd0);
    chk("abort:drain_i_ready", 32'(agu_i_ready), 32'd1);
    @(negedge clk);
    chk("abort:drain_o_valid2", 32'(agu_o_valid), 32'd0);
    $display("txn abort     reset in RSP, late response drained");
  endtask

  initial begin
    txn_t t;
    repeat (3) @(negedge clk);
    chk_reset_state("por");
    rst_n = 1'b1;

    run_txn("lw",     mk(1, 2, 0, 32'h8000_0000, 32'd4, 32'd0, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, 0));
    run_txn("lb",     mk(1, 0, 0, 32'h1000_0000, 32'd3, 32'd0, 5'd7, 32'h8000_0000, 0, 0, 0, 0));
    run_txn("lbu",    mk(1, 0, 1, 32'h1000_0000, 32'd3, 32'd0, 5'd7, 32'h8000_0000, 0, 0, 0, 0));
    run_txn("sh",     mk(0, 1, 0, 32'h1000_0000, 32'd2, 32'h1234_ABCD, 5'd9, 32'd0, 0, 0, 0, 0));
    run_txn("lw_mis", mk(1, 2, 0, 32'h1000_0000, 32'd1, 32'd0, 5'd4, 32'd0, 0, 0, 0, 0));
    run_txn("bp_err", mk(1, 2, 0, 32'h4000_0000, 32'd16, 32'd0, 5'd6, 32'h1111_2222, 1, 3, 1, 2));
    run_txn("lh_neg", mk(1, 1, 0, 32'h0000_0FFE, 32'hFFFF_FFF4, 32'd0, 5'd0, 32'h8001_7FFF, 0, 1, 2, 1));
    run_txn("wrap",   mk(1, 3, 0, 32'hFFFF_FFFC, 32'd8, 32'd0, 5'd1, 32'h0BAD_F00D, 0, 0, 0, 0));
    reset_abort();
    run_txn("lw_post", mk(1, 2, 0, 32'h8000_0000, 32'd4, 32'd0, 5'd5, 32'h0123_4567, 0, 0, 0, 0));

    for (int i = 0; i < 150; i++) begin
      t = mk(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
             5'($urandom), $urandom, ($urandom % 8) == 0,
             int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      if ($urandom % 2 == 1) begin
        t.rs1 = t.rs1 & 32'hFFFF_FFFC;
        t.imm = t.imm & 32'hFFFF_FFFC;
      end
      run_txn("rand", t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
